// File: rtl/neuron_pkg.sv
`default_nettype none
// ============================================================================
// Module   : neuron_pkg
// Purpose  : Shared Q32.32 constants, synapse type codes and accumulator
//            state encodings for the neuron pipeline.
// Revision : 1.0 - initial release
// ============================================================================
package neuron_pkg;

  localparam int Q_INTEGER_WIDTH = 32;
  localparam int Q_FRAC_WIDTH    = 32;
  localparam int Q_DATA_WIDTH    = Q_INTEGER_WIDTH + Q_FRAC_WIDTH;

  // Saturation rails of the signed Q32.32 format
  localparam logic [Q_DATA_WIDTH-1:0] Q_MAX = {1'b0, {(Q_DATA_WIDTH-1){1'b1}}};
  localparam logic [Q_DATA_WIDTH-1:0] Q_MIN = {1'b1, {(Q_DATA_WIDTH-1){1'b0}}};

  // Synapse type encodings
  localparam logic SYN_EX = 1'b0;
  localparam logic SYN_IN = 1'b1;

  // Accumulator states
  localparam logic [0:0] ST_ACCUM = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

endpackage : neuron_pkg
`default_nettype wire

// File: rtl/synaptic_weight_accumulator_sat_add_q.sv
`default_nettype none
// ============================================================================
// Module   : sat_add_q
// Purpose  : Combinational signed saturating adder for Q-format values.
// Revision : 1.0 - initial release
// ============================================================================
module sat_add_q #(
  parameter int DATA_WIDTH = 64
) (
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic [DATA_WIDTH-1:0] sum_o
);

  localparam logic [DATA_WIDTH-1:0] c_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] c_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic [DATA_WIDTH-1:0] w_raw;
  logic                  w_ovf;

  // Overflow only when both operands share a sign and the wrapped result flips it
  always_comb begin
    w_raw = a_i + b_i;
    w_ovf = (a_i[DATA_WIDTH-1] == b_i[DATA_WIDTH-1]) &&
            (w_raw[DATA_WIDTH-1] != a_i[DATA_WIDTH-1]);
    if (w_ovf) begin
      sum_o = a_i[DATA_WIDTH-1] ? c_MIN : c_MAX;
    end else begin
      sum_o = w_raw;
    end
  end

endmodule : sat_add_q
`default_nettype wire

// File: rtl/synaptic_weight_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : synaptic_weight_accumulator
// Purpose  : Accumulates weighted synaptic events into per-neuron excitatory
//            and inhibitory Q32.32 sums during a timestep, then streams and
//            clears each neuron's pair over a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module synaptic_weight_accumulator
  import neuron_pkg::*;
#(
  parameter int INTEGER_WIDTH     = Q_INTEGER_WIDTH,
  parameter int DATA_WIDTH_FRAC   = Q_FRAC_WIDTH,
  parameter int DATA_WIDTH        = INTEGER_WIDTH + DATA_WIDTH_FRAC,
  parameter int NEURON_ADDR_WIDTH = 3,
  parameter int NUM_NEURONS       = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         syn_valid_i,
  output logic                         syn_ready_o,
  input  logic [NEURON_ADDR_WIDTH-1:0] syn_neuron_addr_i,
  input  logic                         syn_type_i,
  input  logic [DATA_WIDTH-1:0]        syn_weight_i,
  input  logic                         step_end_i,
  output logic                         sum_valid_o,
  input  logic                         sum_ready_i,
  output logic [NEURON_ADDR_WIDTH-1:0] sum_neuron_addr_o,
  output logic [DATA_WIDTH-1:0]        ex_weight_sum_o,
  output logic [DATA_WIDTH-1:0]        in_weight_sum_o,
  output logic                         step_done_o,
  output logic                         step_overrun_o
);

  localparam logic [NEURON_ADDR_WIDTH-1:0] c_LAST_IDX = NEURON_ADDR_WIDTH'(NUM_NEURONS - 1);

  logic [0:0]                   state_q, state_d;
  logic [NEURON_ADDR_WIDTH-1:0] drain_idx_q, drain_idx_d;
  logic [DATA_WIDTH-1:0]        ex_q [NUM_NEURONS];
  logic [DATA_WIDTH-1:0]        ex_d [NUM_NEURONS];
  logic [DATA_WIDTH-1:0]        in_q [NUM_NEURONS];
  logic [DATA_WIDTH-1:0]        in_d [NUM_NEURONS];
  logic                         syn_ready_q, syn_ready_d;
  logic                         sum_valid_q, sum_valid_d;
  logic [NEURON_ADDR_WIDTH-1:0] sum_addr_q, sum_addr_d;
  logic [DATA_WIDTH-1:0]        ex_out_q, ex_out_d;
  logic [DATA_WIDTH-1:0]        in_out_q, in_out_d;
  logic                         step_done_q, step_done_d;
  logic                         overrun_q, overrun_d;

  logic                         w_accept;
  logic                         w_addr_ok;
  logic [NEURON_ADDR_WIDTH-1:0] w_rd_idx;
  logic                         w_acc_ex;
  logic                         w_acc_in;
  logic                         w_pop;
  logic                         w_close;
  logic [DATA_WIDTH-1:0]        w_ex_cur;
  logic [DATA_WIDTH-1:0]        w_in_cur;
  logic [DATA_WIDTH-1:0]        w_ex_sum;
  logic [DATA_WIDTH-1:0]        w_in_sum;

  // Event qualification; out-of-range addresses are accepted but never written
  always_comb begin
    w_accept  = syn_valid_i & syn_ready_q;
    w_addr_ok = (int'(syn_neuron_addr_i) < NUM_NEURONS);
    w_rd_idx  = w_addr_ok ? syn_neuron_addr_i : '0;
    w_acc_ex  = w_accept & w_addr_ok & (syn_type_i == SYN_EX);
    w_acc_in  = w_accept & w_addr_ok & (syn_type_i == SYN_IN);
    w_pop     = sum_valid_q & sum_ready_i;
    w_close   = step_end_i & (state_q == ST_ACCUM);
    w_ex_cur  = ex_q[w_rd_idx];
    w_in_cur  = in_q[w_rd_idx];
  end

  sat_add_q #(.DATA_WIDTH(DATA_WIDTH)) u_ex_add (
    .a_i   (w_ex_cur),
    .b_i   (syn_weight_i),
    .sum_o (w_ex_sum)
  );

  sat_add_q #(.DATA_WIDTH(DATA_WIDTH)) u_in_add (
    .a_i   (w_in_cur),
    .b_i   (syn_weight_i),
    .sum_o (w_in_sum)
  );

  // Next-state of the ACCUM/DRAIN controller, drain index and status flags
  always_comb begin
    state_d     = state_q;
    drain_idx_d = drain_idx_q;
    step_done_d = 1'b0;
    overrun_d   = overrun_q | (step_end_i & (state_q == ST_DRAIN));
    case (state_q)
      ST_ACCUM: begin
        if (w_close) begin
          state_d     = ST_DRAIN;
          drain_idx_d = '0;
        end
      end
      ST_DRAIN: begin
        if (w_pop) begin
          if (drain_idx_q == c_LAST_IDX) begin
            state_d     = ST_ACCUM;
            drain_idx_d = '0;
            step_done_d = 1'b1;
          end else begin
            drain_idx_d = drain_idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d     = ST_ACCUM;
        drain_idx_d = '0;
      end
    endcase
  end

  // Bank next-state: accumulate the addressed entry, clear the consumed one
  always_comb begin
    for (int i = 0; i < NUM_NEURONS; i++) begin
      ex_d[i] = ex_q[i];
      in_d[i] = in_q[i];
      if (w_acc_ex && (int'(w_rd_idx) == i)) begin
        ex_d[i] = w_ex_sum;
      end
      if (w_acc_in && (int'(w_rd_idx) == i)) begin
        in_d[i] = w_in_sum;
      end
      if (w_pop && (int'(drain_idx_q) == i)) begin
        ex_d[i] = '0;
        in_d[i] = '0;
      end
    end
  end

  // Output next-state reads the post-update bank so a same-cycle event is seen
  always_comb begin
    syn_ready_d = (state_d == ST_ACCUM);
    sum_valid_d = (state_d == ST_DRAIN);
    sum_addr_d  = '0;
    ex_out_d    = '0;
    in_out_d    = '0;
    if (sum_valid_d) begin
      sum_addr_d = drain_idx_d;
      ex_out_d   = ex_d[drain_idx_d];
      in_out_d   = in_d[drain_idx_d];
    end
  end

  // Bank storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        ex_q[i] <= '0;
        in_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        ex_q[i] <= ex_d[i];
        in_q[i] <= in_d[i];
      end
    end
  end

  // Controller and registered output stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ACCUM;
      drain_idx_q <= '0;
      syn_ready_q <= 1'b0;
      sum_valid_q <= 1'b0;
      sum_addr_q  <= '0;
      ex_out_q    <= '0;
      in_out_q    <= '0;
      step_done_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_idx_q <= drain_idx_d;
      syn_ready_q <= syn_ready_d;
      sum_valid_q <= sum_valid_d;
      sum_addr_q  <= sum_addr_d;
      ex_out_q    <= ex_out_d;
      in_out_q    <= in_out_d;
      step_done_q <= step_done_d;
      overrun_q   <= overrun_d;
    end
  end

  assign syn_ready_o       = syn_ready_q;
  assign sum_valid_o       = sum_valid_q;
  assign sum_neuron_addr_o = sum_addr_q;
  assign ex_weight_sum_o   = ex_out_q;
  assign in_weight_sum_o   = in_out_q;
  assign step_done_o       = step_done_q;
  assign step_overrun_o    = overrun_q;

endmodule : synaptic_weight_accumulator
`default_nettype wire

// File: tb/tb_synaptic_weight_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_synaptic_weight_accumulator
// Purpose  : Directed scoreboard bench for synaptic_weight_accumulator; a
//            6-neuron instance covers the out-of-range address case.
// Revision : 1.0 - initial release
// ============================================================================
module tb_synaptic_weight_accumulator;

  localparam logic [63:0] MAXV = 64'h7FFFFFFF_FFFFFFFF;
  localparam logic [63:0] MINV = 64'h80000000_00000000;

  typedef struct {
    logic [2:0]  a;
    logic [63:0] e;
    logic [63:0] i;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        syn_valid = 1'b0;
  logic [2:0]  syn_addr = '0;
  logic        syn_type = 1'b0;
  logic [63:0] syn_weight = '0;
  logic        step_end = 1'b0;
  logic        sum_ready = 1'b0;
  logic        sel = 1'b0;

  logic        m_syn_ready, m_sum_valid, m_step_done, m_overrun;
  logic [2:0]  m_addr;
  logic [63:0] m_ex, m_in;
  logic        s_syn_ready, s_sum_valid, s_step_done, s_overrun;
  logic [2:0]  s_addr;
  logic [63:0] s_ex, s_in;

  int total = 0;
  int bad   = 0;
  exp_t q[$];
  logic [63:0] mex [8];
  logic [63:0] mix [8];

  always #5 clk = ~clk;

  synaptic_weight_accumulator #(.NUM_NEURONS(8)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .syn_valid_i(syn_valid & ~sel), .syn_ready_o(m_syn_ready),
    .syn_neuron_addr_i(syn_addr), .syn_type_i(syn_type), .syn_weight_i(syn_weight),
    .step_end_i(step_end & ~sel),
    .sum_valid_o(m_sum_valid), .sum_ready_i(sum_ready),
    .sum_neuron_addr_o(m_addr), .ex_weight_sum_o(m_ex), .in_weight_sum_o(m_in),
    .step_done_o(m_step_done), .step_overrun_o(m_overrun)
  );

  synaptic_weight_accumulator #(.NUM_NEURONS(6)) u_dut6 (
    .clk(clk), .rst_n(rst_n),
    .syn_valid_i(syn_valid & sel), .syn_ready_o(s_syn_ready),
    .syn_neuron_addr_i(syn_addr), .syn_type_i(syn_type), .syn_weight_i(syn_weight),
    .step_end_i(step_end & sel),
    .sum_valid_o(s_sum_valid), .sum_ready_i(sum_ready),
    .sum_neuron_addr_o(s_addr), .ex_weight_sum_o(s_ex), .in_weight_sum_o(s_in),
    .step_done_o(s_step_done), .step_overrun_o(s_overrun)
  );

  wire        w_syn_ready = sel ? s_syn_ready : m_syn_ready;
  wire        w_sum_valid = sel ? s_sum_valid : m_sum_valid;
  wire        w_step_done = sel ? s_step_done : m_step_done;
  wire        w_overrun   = sel ? s_overrun   : m_overrun;
  wire [2:0]  w_addr      = sel ? s_addr      : m_addr;
  wire [63:0] w_ex        = sel ? s_ex        : m_ex;
  wire [63:0] w_in        = sel ? s_in        : m_in;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int nn();
    return sel ? 6 : 8;
  endfunction

  // Reference saturating add computed with one guard bit
  function automatic logic [63:0] sat(input logic [63:0] a, input logic [63:0] b);
    logic signed [64:0] s;
    s = $signed({a[63], a}) + $signed({b[63], b});
    if (s > $signed({1'b0, MAXV})) return MAXV;
    if (s < $signed({1'b1, MINV})) return MINV;
    return s[63:0];
  endfunction

  task automatic clear_model;
    for (int k = 0; k < 8; k++) begin
      mex[k] = '0;
      mix[k] = '0;
    end
  endtask

  task automatic push_all;
    for (int k = 0; k < nn(); k++) begin
      exp_t e;
      e.a = 3'(k);
      e.e = mex[k];
      e.i = mix[k];
      q.push_back(e);
    end
    clear_model();
  endtask

  task automatic ev(input logic [2:0] a, input logic t, input logic [63:0] w, input logic with_end);
    chk("syn_ready_accum", 64'(w_syn_ready), 64'd1);
    syn_valid  = 1'b1;
    syn_addr   = a;
    syn_type   = t;
    syn_weight = w;
    step_end   = with_end;
    if (int'(a) < nn()) begin
      if (t) mix[a] = sat(mix[a], w);
      else   mex[a] = sat(mex[a], w);
    end
    if (with_end) push_all();
    tick();
    syn_valid = 1'b0;
    step_end  = 1'b0;
  endtask

  task automatic end_step;
    step_end = 1'b1;
    push_all();
    tick();
    step_end = 1'b0;
  endtask

  task automatic pop_cmp;
    exp_t e;
    if (q.size() == 0) begin
      chk("queue_empty", 64'(q.size()), 64'd1);
    end else begin
      e = q.pop_front();
      chk("sum_addr", 64'(w_addr), 64'(e.a));
      chk("ex_sum", w_ex, e.e);
      chk("in_sum", w_in, e.i);
    end
  endtask

  // mode 0: ready held high; 1: ready pattern 1,0,0,1 plus SynValid pulses;
  // 2: as 1 with a StepEnd pulse inside the drain
  task automatic drain(input int mode);
    int          got  = 0;
    int          cyc  = 0;
    logic        held = 1'b0;
    logic        r;
    logic [2:0]  ha;
    logic [63:0] he, hi;
    while (got < nn() && cyc < 200) begin
      r = (mode == 0) || (cyc % 4 == 0) || (cyc % 4 == 3);
      sum_ready = r;
      syn_valid = (mode != 0) && (cyc % 3 == 1);
      syn_addr  = 3'(cyc);
      syn_weight = 64'h1_00000000;
      step_end  = (mode == 2) && (cyc == 2);
      chk("syn_ready_drain", 64'(w_syn_ready), 64'd0);
      chk("sum_valid", 64'(w_sum_valid), 64'd1);
      if (held) begin
        chk("stall_addr", 64'(w_addr), 64'(ha));
        chk("stall_ex", w_ex, he);
        chk("stall_in", w_in, hi);
      end
      if (r && w_sum_valid) begin
        pop_cmp();
        got++;
        held = 1'b0;
      end else begin
        ha = w_addr; he = w_ex; hi = w_in;
        held = 1'b1;
      end
      tick();
      cyc++;
    end
    syn_valid = 1'b0;
    step_end  = 1'b0;
    sum_ready = 1'b0;
    chk("drain_count", 64'(got), 64'(nn()));
    chk("step_done_pulse", 64'(w_step_done), 64'd1);
    chk("sum_valid_after", 64'(w_sum_valid), 64'd0);
    chk("syn_ready_after", 64'(w_syn_ready), 64'd1);
    tick();
    chk("step_done_single", 64'(w_step_done), 64'd0);
  endtask

  initial begin
    clear_model();
    // Reset state
    repeat (2) tick();
    chk("rst_syn_ready", 64'(w_syn_ready), 64'd0);
    chk("rst_sum_valid", 64'(w_sum_valid), 64'd0);
    chk("rst_addr", 64'(w_addr), 64'd0);
    chk("rst_ex", w_ex, 64'd0);
    chk("rst_in", w_in, 64'd0);
    chk("rst_done", 64'(w_step_done), 64'd0);
    chk("rst_overrun", 64'(w_overrun), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rel_syn_ready", 64'(w_syn_ready), 64'd1);

    // Basic accumulation into n2
    ev(3'd2, 1'b0, 64'h00000001_80000000, 1'b0);
    ev(3'd2, 1'b0, 64'h00000000_40000000, 1'b0);
    ev(3'd2, 1'b1, 64'h00000003_00000000, 1'b0);
    end_step();
    drain(0);

    // Event in the same cycle as StepEnd, then an empty step
    ev(3'd0, 1'b0, 64'h00000001_00000000, 1'b1);
    drain(0);
    end_step();
    drain(0);

    // Saturation at both rails, drained under backpressure
    ev(3'd1, 1'b0, 64'h7FFFFFFF_00000000, 1'b0);
    ev(3'd1, 1'b0, 64'h7FFFFFFF_00000000, 1'b0);
    ev(3'd1, 1'b1, 64'h80000000_00000001, 1'b0);
    ev(3'd1, 1'b1, 64'h80000000_00000001, 1'b0);
    ev(3'd5, 1'b1, 64'hFFFFFFFF_80000000, 1'b0);
    end_step();
    drain(1);

    // StepEnd during drain sets the sticky overrun flag
    ev(3'd4, 1'b1, 64'h00000002_00000000, 1'b0);
    ev(3'd7, 1'b0, 64'hFFFFFFFE_00000000, 1'b0);
    end_step();
    drain(2);
    chk("overrun_set", 64'(w_overrun), 64'd1);
    end_step();
    drain(0);
    chk("overrun_sticky", 64'(w_overrun), 64'd1);

    // Reset in the middle of a drain
    ev(3'd3, 1'b0, 64'h00000005_00000000, 1'b0);
    ev(3'd6, 1'b1, 64'h00000000_00000001, 1'b0);
    end_step();
    sum_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("pre_rst_valid", 64'(w_sum_valid), 64'd1);
      pop_cmp();
      tick();
    end
    sum_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_sum_valid", 64'(w_sum_valid), 64'd0);
    chk("arst_addr", 64'(w_addr), 64'd0);
    chk("arst_ex", w_ex, 64'd0);
    chk("arst_in", w_in, 64'd0);
    chk("arst_overrun", 64'(w_overrun), 64'd0);
    chk("arst_syn_ready", 64'(w_syn_ready), 64'd0);
    q.delete();
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rel2_syn_ready", 64'(w_syn_ready), 64'd1);
    chk("rel2_overrun", 64'(w_overrun), 64'd0);
    end_step();
    drain(0);

    // Six-neuron instance: out-of-range addresses are dropped
    sel = 1'b1;
    tick();
    chk("n6_syn_ready", 64'(w_syn_ready), 64'd1);
    ev(3'd7, 1'b0, 64'h00000001_00000000, 1'b0);
    ev(3'd6, 1'b1, 64'h00000001_00000000, 1'b0);
    ev(3'd5, 1'b1, 64'h00000002_00000000, 1'b0);
    end_step();
    drain(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_synaptic_weight_accumulator
`default_nettype wire
